// File: rtl/cpu_fwd_pkg.sv
// rtl/cpu_fwd_pkg.sv - shared types and constants for MEM-stage store forwarding
package cpu_fwd_pkg;

  localparam logic [1:0] REG_TYPE_INT = 2'b00;

  localparam int FWD_SRC_NONE = 0;
  localparam int FWD_SRC_WB   = 1;

  localparam int FWD_ENTRY_ADDR_WIDTH = 5;
  localparam int FWD_ENTRY_DATA_WIDTH = 32;

  // Entry layout at the default register widths; the history buffer keeps the same field order.
  typedef struct packed {
    logic                            valid;
    logic                            is_float;
    logic [FWD_ENTRY_ADDR_WIDTH-1:0] addr;
    logic [FWD_ENTRY_DATA_WIDTH-1:0] data;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_history_buf.sv
// rtl/fwd_history_buf.sv - DEPTH-entry shift history of retired register writebacks
module fwd_history_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic                                 wr_valid,
  input  logic                                 wr_is_float,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic [DEPTH-1:0]                     hist_valid,
  output logic [DEPTH-1:0]                     hist_is_float,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     hist_addr,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]     hist_data
);

  // Only valid bits are reset; payload fields are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid <= '0;
    end else if (!stall) begin
      hist_valid[0]    <= wr_valid;
      hist_is_float[0] <= wr_is_float;
      hist_addr[0]     <= wr_addr;
      hist_data[0]     <= wr_data;
      for (int k = 1; k < DEPTH; k++) begin
        hist_valid[k]    <= hist_valid[k-1];
        hist_is_float[k] <= hist_is_float[k-1];
        hist_addr[k]     <= hist_addr[k-1];
        hist_data[k]     <= hist_data[k-1];
      end
    end
  end

endmodule

// File: rtl/mem_store_forward_unit.sv
// rtl/mem_store_forward_unit.sv - store-data forwarding from WB and writeback history
// Optional writeback-hit counter output HIT_COUNT under MEM_FWD_HIT_COUNT_EN.
module mem_store_forward_unit
  import cpu_fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2,
  parameter int SRC_WIDTH  = $clog2(DEPTH + 2)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  STALL,
  input  logic                  MEM_DATA_MEM_WRITE,
  input  logic [1:0]            MEM_REG_TYPE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_REG_DATA,
  input  logic                  WB_WRITE_EN,
  input  logic                  WB_F_WRITE_EN,
  input  logic [ADDR_WIDTH-1:0] WB_ADDR,
  input  logic [DATA_WIDTH-1:0] WB_DATA,
`ifdef MEM_FWD_HIT_COUNT_EN
  output logic [31:0]           HIT_COUNT,
`endif
  output logic [DATA_WIDTH-1:0] MEM_STORE_DATA,
  output logic                  MEM_FWD_SEL,
  output logic [SRC_WIDTH-1:0]  MEM_FWD_SRC
);

  logic                             wb_valid;
  logic                             wb_is_float;
  logic                             mem_is_float;
  logic [DEPTH-1:0]                 hist_valid;
  logic [DEPTH-1:0]                 hist_is_float;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] hist_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] hist_data;

  // x0 writes are discarded; f0 is a real register; int enable wins over float.
  assign wb_is_float  = !WB_WRITE_EN;
  assign wb_valid     = WB_WRITE_EN ? (WB_ADDR != '0) : WB_F_WRITE_EN;
  assign mem_is_float = (MEM_REG_TYPE != REG_TYPE_INT);

  fwd_history_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_hist (
    .clk           (CLK),
    .reset         (RESET),
    .stall         (STALL),
    .wr_valid      (wb_valid),
    .wr_is_float   (wb_is_float),
    .wr_addr       (WB_ADDR),
    .wr_data       (WB_DATA),
    .hist_valid    (hist_valid),
    .hist_is_float (hist_is_float),
    .hist_addr     (hist_addr),
    .hist_data     (hist_data)
  );

  // Scan oldest to youngest so later (younger) matches override; WB is checked last.
  always_comb begin
    MEM_FWD_SEL    = 1'b0;
    MEM_FWD_SRC    = SRC_WIDTH'(FWD_SRC_NONE);
    MEM_STORE_DATA = MEM_REG_DATA;
    if (MEM_DATA_MEM_WRITE && !RESET) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hist_valid[k] && (hist_is_float[k] == mem_is_float) && (hist_addr[k] == MEM_ADDR)) begin
          MEM_FWD_SEL    = 1'b1;
          MEM_FWD_SRC    = SRC_WIDTH'(k + 2);
          MEM_STORE_DATA = hist_data[k];
        end
      end
      if (wb_valid && (wb_is_float == mem_is_float) && (WB_ADDR == MEM_ADDR)) begin
        MEM_FWD_SEL    = 1'b1;
        MEM_FWD_SRC    = SRC_WIDTH'(FWD_SRC_WB);
        MEM_STORE_DATA = WB_DATA;
      end
    end
  end

`ifdef MEM_FWD_HIT_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT <= '0;
    end else if (MEM_FWD_SEL && !STALL) begin
      HIT_COUNT <= HIT_COUNT + 32'd1;
    end
  end
`endif

endmodule
